// File: rtl/cnn_layer_sched.sv
// Layer-level sequencer for the CNN accelerator: walks NUM_LAYERS layers through
// conv (and optional pool) runs, each guarded by a shared watchdog.
module cnn_layer_sched #(
    parameter int          NUM_LAYERS = 3,
    parameter logic [7:0]  POOL_MASK  = 8'b0000_0101,
    parameter logic [15:0] TIMEOUT    = 16'd40000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] layer,
    output logic       conv_rst,
    output logic       conv_en,
    input  logic       conv_finish,
    output logic       pool_rst,
    output logic       pool_en,
    input  logic       pool_finish
);

    // state    | meaning
    // IDLE     | waiting for start
    // CONV_RST | one-cycle reset pulse to conv controller
    // CONV_RUN | conv enabled, watchdog counting
    // POOL_RST | one-cycle reset pulse to pooling engine
    // POOL_RUN | pool enabled, watchdog counting
    // NEXT     | advance layer index or finish the pass
    // DONE     | one-cycle completion pulse
    // ERR      | watchdog expired, held until abort or reset
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CONV_RST = 3'd1;
    localparam logic [2:0] CONV_RUN = 3'd2;
    localparam logic [2:0] POOL_RST = 3'd3;
    localparam logic [2:0] POOL_RUN = 3'd4;
    localparam logic [2:0] NEXT     = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;
    localparam logic [2:0] ERR      = 3'd7;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] wdog;
    logic        wdog_tc;
    logic        last_layer;
    logic        pool_sel;

    assign wdog_tc    = (wdog == TIMEOUT - 16'd1);
    assign last_layer = (layer == 8'(NUM_LAYERS - 1));
    // Only the low eight layers can be flagged for pooling.
    assign pool_sel   = (layer < 8'd8) ? POOL_MASK[layer[2:0]] : 1'b0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = CONV_RST;
            CONV_RST: state_nxt = CONV_RUN;
            CONV_RUN: begin
                if (conv_finish)  state_nxt = pool_sel ? POOL_RST : NEXT;
                else if (wdog_tc) state_nxt = ERR;
            end
            POOL_RST: state_nxt = POOL_RUN;
            POOL_RUN: begin
                if (pool_finish)  state_nxt = NEXT;
                else if (wdog_tc) state_nxt = ERR;
            end
            NEXT:     state_nxt = last_layer ? DONE : CONV_RST;
            DONE:     state_nxt = IDLE;
            ERR:      state_nxt = ERR;
            default:  state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wdog  <= 16'd0;
            layer <= 8'd0;
        end else begin
            state <= state_nxt;

            if (abort || state == CONV_RST || state == POOL_RST)
                wdog <= 16'd0;
            else if (state == CONV_RUN || state == POOL_RUN)
                wdog <= wdog + 16'd1;

            if (abort || (state == IDLE && start))
                layer <= 8'd0;
            else if (state == NEXT && !last_layer)
                layer <= layer + 8'd1;
        end
    end

    // ERR is left only through abort or reset, so the sticky flag is the state itself.
    assign busy     = (state != IDLE) && (state != DONE) && (state != ERR);
    assign done     = (state == DONE);
    assign error    = (state == ERR);
    assign conv_rst = (state == CONV_RST);
    assign conv_en  = (state == CONV_RUN);
    assign pool_rst = (state == POOL_RST);
    assign pool_en  = (state == POOL_RUN);

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Directed bench for cnn_layer_sched: a table-driven full pass plus hand
// sequences for watchdog, finish/timeout race, abort and mid-run reset.
module tb_cnn_layer_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       conv_finish = 1'b0;
    logic       pool_finish = 1'b0;
    logic       busy, done, error, conv_rst, conv_en, pool_rst, pool_en;
    logic [7:0] layer;

    int checks = 0;
    int errors = 0;

    // Output vector order: busy, done, error, conv_rst, conv_en, pool_rst, pool_en
    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_CRST = 7'b1001000;
    localparam logic [6:0] O_CRUN = 7'b1000100;
    localparam logic [6:0] O_PRST = 7'b1000010;
    localparam logic [6:0] O_PRUN = 7'b1000001;
    localparam logic [6:0] O_NEXT = 7'b1000000;
    localparam logic [6:0] O_DONE = 7'b0100000;
    localparam logic [6:0] O_ERR  = 7'b0010000;

    typedef struct {
        logic       s;
        logic       a;
        logic       cf;
        logic       pf;
        int         n;
        logic [6:0] o;
        logic [7:0] l;
    } vec_t;

    vec_t vecs[18];

    cnn_layer_sched #(
        .NUM_LAYERS(3),
        .POOL_MASK (8'b0000_0101),
        .TIMEOUT   (16'd16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .layer      (layer),
        .conv_rst   (conv_rst),
        .conv_en    (conv_en),
        .conv_finish(conv_finish),
        .pool_rst   (pool_rst),
        .pool_en    (pool_en),
        .pool_finish(pool_finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] exp_o, input logic [7:0] exp_l);
        logic [6:0] act_o;
        act_o = {busy, done, error, conv_rst, conv_en, pool_rst, pool_en};
        checks++;
        if (act_o !== exp_o || layer !== exp_l) begin
            errors++;
            $display("FAIL %s: outs=%b layer=%0d, required outs=%b layer=%0d",
                     name, act_o, layer, exp_o, exp_l);
        end
    endtask

    task automatic step(input logic s, input logic a, input logic cf, input logic pf);
        @(negedge clk);
        start = s;
        abort = a;
        conv_finish = cf;
        pool_finish = pf;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 18; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                step(vecs[i].s, vecs[i].a, vecs[i].cf, vecs[i].pf);
                check($sformatf("%s_row%0d_c%0d", tag, i, k), vecs[i].o, vecs[i].l);
            end
        end
    endtask

    initial begin
        // Full pass: conv L0 (10) -> pool L0 (4) -> conv L1 -> conv L2 -> pool L2.
        // Stale finishes are held high through each reset state.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  O_CRST, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, O_CRUN, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  O_PRST, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4,  O_PRUN, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  O_NEXT, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  O_CRST, 8'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  O_CRUN, 8'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 9,  O_CRUN, 8'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  O_NEXT, 8'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  O_CRST, 8'd2};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  O_CRUN, 8'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 9,  O_CRUN, 8'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  O_PRST, 8'd2};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  O_PRUN, 8'd2};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 3,  O_PRUN, 8'd2};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  O_NEXT, 8'd2};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  O_DONE, 8'd2};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 3,  O_IDLE, 8'd2};

        repeat (2) @(posedge clk);
        #1;
        check("reset_held", O_IDLE, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", O_IDLE, 8'd0);

        run_table("pass1");

        // Watchdog: conv_en high for 16 cycles, then ERR.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("wd_crst", O_CRST, 8'd0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("wd_run%0d", k), O_CRUN, 8'd0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("wd_err", O_ERR, 8'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("err_start_ignored%0d", k), O_ERR, 8'd0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("err_abort", O_IDLE, 8'd0);

        // Finish arrives in the cycle wdog==15: finish wins.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("race_crst", O_CRST, 8'd0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("race_run%0d", k), O_CRUN, 8'd0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("race_finish_wins", O_PRST, 8'd0);

        // Abort during POOL_RUN of layer 0.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_prun0", O_PRUN, 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_prun1", O_PRUN, 8'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("abort_to_idle", O_IDLE, 8'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("abort_no_done%0d", k), O_IDLE, 8'd0);
        end

        // Fresh start after abort, then reset asserted mid CONV_RUN of layer 1.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("restart_crst", O_CRST, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_crun", O_CRUN, 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("restart_prst", O_PRST, 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("restart_prun", O_PRUN, 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("restart_next", O_NEXT, 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("restart_crst1", O_CRST, 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_crun1", O_CRUN, 8'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_mid_run", O_IDLE, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_reset_idle", O_IDLE, 8'd0);

        run_table("pass2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
